// File: rtl/fetch_seq.sv
// Instruction fetch/sequencing controller: owns PC, latches IR, resolves BNE.
// Optional FETCH_HALT_EN: an all-zero instruction word parks the FSM in HALT.
module fetch_seq #(
  parameter int WORD_W = 8,
  parameter int OP_W   = 3,
  parameter logic [OP_W-1:0] OP_LOAD  = OP_W'(2),
  parameter logic [OP_W-1:0] OP_STORE = OP_W'(3),
  parameter logic [OP_W-1:0] OP_BNE   = OP_W'(6),
  localparam int A_W = WORD_W - OP_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              run,
  output logic [A_W-1:0]    Iaddress,
  input  logic [WORD_W-1:0] Idata,
  input  logic              z_flag,
  output logic [OP_W-1:0]   opcode,
  output logic [A_W-1:0]    operand,
  output logic              exec_valid,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              busy,
  output logic              halted
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_EXEC  = 3'd2;
  localparam logic [2:0] S_MEM   = 3'd3;
  localparam logic [2:0] S_HALT  = 3'd4;

  logic [2:0]        r_state;
  logic [A_W-1:0]    r_pc;
  logic [WORD_W-1:0] r_ir;

  logic [2:0]        w_state_nxt;
  logic [A_W-1:0]    w_pc_nxt;
  logic [2:0]        w_bound;
  logic [A_W-1:0]    w_pc_inc;
  logic              w_is_mem;
  logic              w_is_bne;

  assign opcode   = r_ir[WORD_W-1:A_W];
  assign operand  = r_ir[A_W-1:0];
  assign Iaddress = r_pc;

  assign w_pc_inc = r_pc + A_W'(1);
  assign w_bound  = run ? S_FETCH : S_IDLE;
  assign w_is_mem = (opcode == OP_LOAD) || (opcode == OP_STORE);
  assign w_is_bne = (opcode == OP_BNE);

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    unique case (r_state)
      S_IDLE: begin
        if (run) w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        w_state_nxt = S_EXEC;
      end
      S_EXEC: begin
`ifdef FETCH_HALT_EN
        if (r_ir == '0) begin
          w_state_nxt = S_HALT;
        end else
`endif
        begin
          unique case (1'b1)
            w_is_mem: begin
              w_state_nxt = S_MEM;
            end
            w_is_bne: begin
              w_pc_nxt    = z_flag ? w_pc_inc : operand;
              w_state_nxt = w_bound;
            end
            default: begin
              w_pc_nxt    = w_pc_inc;
              w_state_nxt = w_bound;
            end
          endcase
        end
      end
      S_MEM: begin
        if (mem_ack) begin
          w_pc_nxt    = w_pc_inc;
          w_state_nxt = w_bound;
        end
      end
      S_HALT: begin
        w_state_nxt = S_HALT;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_pc    <= '0;
      r_ir    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == S_FETCH) r_ir <= Idata;
    end
  end

  assign exec_valid = (r_state == S_EXEC);
  assign mem_req    = (r_state == S_MEM);
  assign busy       = (r_state != S_IDLE) && (r_state != S_HALT);

`ifdef FETCH_HALT_EN
  assign halted = (r_state == S_HALT);
`else
  assign halted = 1'b0;
`endif

endmodule
